socket_transport_pipeline: RTL and testbench

Parametrised, pipelined successor to the combinational socket array: accepts 16-bit-class move instructions (alpha = destination socket, omega = source socket) over a valid/ready handshake and executes them one cycle later. It routes register-file data to NUM_CHANNELS functional-unit channels through per-channel valid/ready handshakes, writes source data into the register file, holds the literal internally, and forwards across read-after-write hazards. It sits between the fetch unit and the register file/functional units of the bsm core.

---
 rtl/bsm_transport_pkg.sv | 23 ++
 rtl/transport_decoder.sv | 46 ++++
 rtl/socket_transport_pipeline.sv | 169 ++++++++++++++++
 tb/tb_socket_transport_pipeline.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsm_transport_pkg.sv
// Shared types for the bsm transport pipeline: operation classes, fixed socket
// numbers and the decoded-op record carried from accept into execute.
package bsm_transport_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_LIT       = 3'd1,
    OP_REG_WRITE = 3'd2,
    OP_SEND      = 3'd3,
    OP_ILLEGAL   = 3'd4
  } op_e;

  localparam int unsigned SOCK_NOP_ALPHA    = 0;
  localparam int unsigned SOCK_NOP_OMEGA    = 1;
  localparam int unsigned SOCK_LITERAL      = 1;
  localparam int unsigned FIRST_PORT_SOURCE = 2;

  typedef struct packed {
    op_e  op;
    logic src_is_literal;
  } dec_op_t;

endpackage

// File: rtl/transport_decoder.sv
// Combinational classification of a {omega, alpha} move instruction into an
// operation class, plus channel/act for SEND moves.
module transport_decoder
  import bsm_transport_pkg::*;
#(
  parameter int unsigned SOCKET_WIDTH     = 8,
  parameter int unsigned NUM_SOURCES      = 8,
  parameter int unsigned NUM_CHANNELS     = 4,
  parameter int unsigned ACTS_PER_CHANNEL = 4,
  localparam int unsigned ACT_WIDTH       = $clog2(ACTS_PER_CHANNEL + 1),
  localparam int unsigned CH_W            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [2*SOCKET_WIDTH-1:0] instruction_i,
  output dec_op_t                   dec_o,
  output logic [CH_W-1:0]           chan_o,
  output logic [ACT_WIDTH-1:0]      act_o
);

  localparam int unsigned REG_BASE   = 2 ** (SOCKET_WIDTH - 1);
  localparam int unsigned SEND_LIMIT = 2 + NUM_CHANNELS * ACTS_PER_CHANNEL;

  int unsigned a, o, rel;

  always_comb begin
    a      = 32'(instruction_i[SOCKET_WIDTH-1:0]);
    o      = 32'(instruction_i[2*SOCKET_WIDTH-1:SOCKET_WIDTH]);
    rel    = a - 2;
    dec_o  = '0;
    chan_o = '0;
    act_o  = '0;
    dec_o.op             = OP_ILLEGAL;
    dec_o.src_is_literal = (o == SOCK_LITERAL);
    if (a == SOCK_NOP_ALPHA) begin
      if (o == SOCK_NOP_OMEGA) dec_o.op = OP_NOP;
    end else if (a == SOCK_LITERAL) begin
      dec_o.op = OP_LIT;
    end else if (a >= REG_BASE) begin
      if (o >= 1 && o <= NUM_SOURCES) dec_o.op = OP_REG_WRITE;
    end else if (o >= REG_BASE && a < SEND_LIMIT) begin
      dec_o.op = OP_SEND;
      chan_o   = CH_W'(rel / ACTS_PER_CHANNEL);
      act_o    = ACT_WIDTH'(rel % ACTS_PER_CHANNEL + 1);
    end
  end

endmodule

// File: rtl/socket_transport_pipeline.sv
// Two-stage move-instruction transport: accept issues the register-file read,
// a single execute slot performs the move, with RAW forwarding from execute.
module socket_transport_pipeline
  import bsm_transport_pkg::*;
#(
  parameter int unsigned SOCKET_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned NUM_SOURCES      = 8,
  parameter int unsigned NUM_CHANNELS     = 4,
  parameter int unsigned ACTS_PER_CHANNEL = 4,
  localparam int unsigned ACT_WIDTH       = $clog2(ACTS_PER_CHANNEL + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [2*SOCKET_WIDTH-1:0]            in_instruction,
  input  logic [(NUM_SOURCES-1)*DATA_WIDTH-1:0] src_data,
  output logic [SOCKET_WIDTH-2:0]              rfu_read_address,
  input  logic [DATA_WIDTH-1:0]                rfu_read_data,
  output logic                                 rfu_write,
  output logic [SOCKET_WIDTH-2:0]              rfu_write_address,
  output logic [DATA_WIDTH-1:0]                rfu_write_data,
  output logic [NUM_CHANNELS-1:0]              ch_valid,
  input  logic [NUM_CHANNELS-1:0]              ch_ready,
  output logic [NUM_CHANNELS*ACT_WIDTH-1:0]    ch_act,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   ch_data,
  output logic                                 illegal_instruction,
  output logic                                 error,
  output logic [2*SOCKET_WIDTH-1:0]            error_instruction,
  input  logic                                 clear_error
);

  localparam int unsigned AW   = SOCKET_WIDTH - 1;
  localparam int unsigned IW   = 2 * SOCKET_WIDTH;
  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  dec_op_t              dec;
  logic [CH_W-1:0]      dec_chan;
  logic [ACT_WIDTH-1:0] dec_act;

  logic                  exec_valid_q, exec_valid_d;
  logic [IW-1:0]         exec_instr_q, exec_instr_d;
  dec_op_t               exec_dec_q, exec_dec_d;
  logic [CH_W-1:0]       exec_chan_q, exec_chan_d;
  logic [ACT_WIDTH-1:0]  exec_act_q, exec_act_d;
  logic                  fwd_valid_q, fwd_valid_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [DATA_WIDTH-1:0] literal_q, literal_d;
  logic                  error_q, error_d;
  logic [IW-1:0]         error_instr_q, error_instr_d;

  logic [SOCKET_WIDTH-1:0] exec_omega;
  logic [DATA_WIDTH-1:0]   src_val, send_data;
  logic                    is_send, sel_ready, exec_done, accept, fwd_hit;

  transport_decoder #(
    .SOCKET_WIDTH     (SOCKET_WIDTH),
    .NUM_SOURCES      (NUM_SOURCES),
    .NUM_CHANNELS     (NUM_CHANNELS),
    .ACTS_PER_CHANNEL (ACTS_PER_CHANNEL)
  ) u_decoder (
    .instruction_i (in_instruction),
    .dec_o         (dec),
    .chan_o        (dec_chan),
    .act_o         (dec_act)
  );

  assign exec_omega = exec_instr_q[IW-1:SOCKET_WIDTH];
  assign send_data  = fwd_valid_q ? fwd_data_q : rfu_read_data;

  always_comb begin
    src_val = '0;
    if (exec_dec_q.src_is_literal) src_val = literal_q;
    for (int unsigned s = FIRST_PORT_SOURCE; s <= NUM_SOURCES; s++) begin
      if (exec_omega == SOCKET_WIDTH'(s))
        src_val = src_data[(s-FIRST_PORT_SOURCE)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    is_send   = exec_valid_q && (exec_dec_q.op == OP_SEND);
    sel_ready = 1'b0;
    ch_valid  = '0;
    ch_act    = '0;
    ch_data   = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (is_send && exec_chan_q == CH_W'(c)) begin
        ch_valid[c]                          = 1'b1;
        ch_act[c*ACT_WIDTH +: ACT_WIDTH]     = exec_act_q;
        ch_data[c*DATA_WIDTH +: DATA_WIDTH]  = send_data;
        sel_ready                            = ch_ready[c];
      end
    end
    exec_done = exec_valid_q && (!is_send || sel_ready);
  end

  assign in_ready            = reset_n && enable && !error_q && (!exec_valid_q || exec_done);
  assign accept              = in_valid && in_ready;
  // A stalled SEND keeps re-reading its own source so rfu_read_data stays valid.
  assign rfu_read_address    = (is_send && !exec_done) ? exec_omega[AW-1:0]
                                                       : in_instruction[SOCKET_WIDTH +: AW];
  assign rfu_write           = exec_valid_q && (exec_dec_q.op == OP_REG_WRITE);
  assign rfu_write_address   = rfu_write ? exec_instr_q[AW-1:0] : '0;
  assign rfu_write_data      = rfu_write ? src_val : '0;
  assign illegal_instruction = exec_valid_q && (exec_dec_q.op == OP_ILLEGAL);
  assign error               = error_q;
  assign error_instruction   = error_instr_q;
  assign fwd_hit             = rfu_write && (exec_instr_q[AW-1:0] == in_instruction[SOCKET_WIDTH +: AW]);

  always_comb begin
    exec_valid_d  = exec_valid_q;
    exec_instr_d  = exec_instr_q;
    exec_dec_d    = exec_dec_q;
    exec_chan_d   = exec_chan_q;
    exec_act_d    = exec_act_q;
    fwd_valid_d   = fwd_valid_q;
    fwd_data_d    = fwd_data_q;
    literal_d     = literal_q;
    error_d       = error_q;
    error_instr_d = error_instr_q;
    if (accept) begin
      exec_valid_d = 1'b1;
      exec_instr_d = in_instruction;
      exec_dec_d   = dec;
      exec_chan_d  = dec_chan;
      exec_act_d   = dec_act;
      fwd_valid_d  = fwd_hit;
      fwd_data_d   = src_val;
    end else if (exec_done) begin
      exec_valid_d = 1'b0;
    end
    if (exec_valid_q && exec_dec_q.op == OP_LIT) literal_d = DATA_WIDTH'(exec_omega);
    if (illegal_instruction) begin
      error_d       = 1'b1;
      error_instr_d = exec_instr_q;
    end else if (clear_error) begin
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exec_valid_q  <= 1'b0;
      exec_instr_q  <= '0;
      exec_dec_q    <= '0;
      exec_chan_q   <= '0;
      exec_act_q    <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_data_q    <= '0;
      literal_q     <= '0;
      error_q       <= 1'b0;
      error_instr_q <= '0;
    end else begin
      exec_valid_q  <= exec_valid_d;
      exec_instr_q  <= exec_instr_d;
      exec_dec_q    <= exec_dec_d;
      exec_chan_q   <= exec_chan_d;
      exec_act_q    <= exec_act_d;
      fwd_valid_q   <= fwd_valid_d;
      fwd_data_q    <= fwd_data_d;
      literal_q     <= literal_d;
      error_q       <= error_d;
      error_instr_q <= error_instr_d;
    end
  end

endmodule

// File: tb/tb_socket_transport_pipeline.sv
// Directed plus randomized bench for socket_transport_pipeline against a
// transaction-level model of the move semantics and a behavioural register file.
module tb_socket_transport_pipeline;

  localparam int C_NOP = 0, C_LIT = 1, C_WR = 2, C_SEND = 3, C_ILL = 4;

  logic        clock = 1'b0;
  logic        reset_n, enable, in_valid, clear_error;
  logic        in_ready;
  logic [15:0] in_instruction;
  logic [55:0] src_data;
  logic [6:0]  rfu_read_address;
  logic [7:0]  rfu_read_data = 8'h00;
  logic        rfu_write;
  logic [6:0]  rfu_write_address;
  logic [7:0]  rfu_write_data;
  logic [3:0]  ch_valid, ch_ready;
  logic [11:0] ch_act;
  logic [31:0] ch_data;
  logic        illegal_instruction, error;
  logic [15:0] error_instruction;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem      [128] = '{default: 8'h00};
  logic [7:0] ref_regs [128] = '{default: 8'h00};

  bit          m_busy, m_err;
  logic [15:0] m_ins, m_errins;
  logic [7:0]  m_lit;
  bit          e_done, e_ready;
  int          e_cls;
  logic [7:0]  e_wdata;

  socket_transport_pipeline #(
    .SOCKET_WIDTH(8), .DATA_WIDTH(8), .NUM_SOURCES(8), .NUM_CHANNELS(4), .ACTS_PER_CHANNEL(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
    .src_data(src_data),
    .rfu_read_address(rfu_read_address), .rfu_read_data(rfu_read_data),
    .rfu_write(rfu_write), .rfu_write_address(rfu_write_address), .rfu_write_data(rfu_write_data),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_act(ch_act), .ch_data(ch_data),
    .illegal_instruction(illegal_instruction), .error(error),
    .error_instruction(error_instruction), .clear_error(clear_error)
  );

  always #5 clock = ~clock;

  // Synchronous-read register file.
  always @(posedge clock) begin
    if (rfu_write) mem[rfu_write_address] <= rfu_write_data;
    rfu_read_data <= mem[rfu_read_address];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void classify(input logic [15:0] ins, output int cls, output int ch, output int act);
    int a, o;
    a = int'(ins[7:0]);
    o = int'(ins[15:8]);
    ch = 0; act = 0;
    if (a == 0)          cls = (o == 1) ? C_NOP : C_ILL;
    else if (a == 1)     cls = C_LIT;
    else if (a >= 128)   cls = (o >= 1 && o <= 8) ? C_WR : C_ILL;
    else if (o >= 128 && a < 18) begin
      cls = C_SEND; ch = (a - 2) / 4; act = (a - 2) % 4 + 1;
    end else             cls = C_ILL;
  endfunction

  function automatic logic [7:0] srcval(input logic [7:0] o);
    if (o == 8'd1) return m_lit;
    if (o >= 8'd2 && o <= 8'd8) return src_data[(int'(o) - 2) * 8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [7:0] a, o;
    case ($urandom_range(0, 5))
      0:       begin o = 8'($urandom_range(0, 255));     a = 8'h01; end
      1:       begin o = 8'($urandom_range(1, 9));       a = 8'(128 + $urandom_range(0, 7)); end
      2, 3:    begin o = 8'(128 + $urandom_range(0, 7)); a = 8'($urandom_range(2, 18)); end
      4:       begin o = 8'h01;                          a = 8'h00; end
      default: begin o = 8'($urandom);                   a = 8'($urandom); end
    endcase
    return {o, a};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_ins = '0; m_errins = '0; m_lit = '0;
  endtask

  task automatic compare();
    int cls, ch, act;
    logic [7:0]  o;
    logic [3:0]  v;
    logic [11:0] va;
    logic [31:0] vd;
    bit send, wr;
    classify(m_ins, cls, ch, act);
    o    = m_ins[15:8];
    send = m_busy && cls == C_SEND;
    wr   = m_busy && cls == C_WR;
    e_cls   = cls;
    e_done  = m_busy && (cls != C_SEND || ch_ready[ch]);
    e_ready = reset_n && enable && !m_err && (!m_busy || e_done);
    e_wdata = wr ? srcval(o) : 8'h00;
    v = '0; va = '0; vd = '0;
    if (send) begin
      v[ch] = 1'b1;
      va[ch*3 +: 3] = 3'(act);
      vd[ch*8 +: 8] = ref_regs[o[6:0]];
    end
    check("in_ready", in_ready, e_ready);
    check("rfu_write", rfu_write, wr);
    check("rfu_write_address", rfu_write_address, wr ? m_ins[6:0] : 7'd0);
    check("rfu_write_data", rfu_write_data, e_wdata);
    check("ch_valid", ch_valid, v);
    check("ch_act", ch_act, va);
    check("ch_data", ch_data, vd);
    check("illegal_instruction", illegal_instruction, m_busy && cls == C_ILL);
    check("error", error, m_err);
    check("error_instruction", error_instruction, m_errins);
    check("rfu_read_address", rfu_read_address, (send && !e_done) ? o[6:0] : in_instruction[14:8]);
  endtask

  task automatic tick();
    bit          acc, clr;
    logic [15:0] ins;
    acc = in_valid && e_ready;
    clr = clear_error;
    ins = in_instruction;
    @(posedge clock);
    if (e_done) begin
      if (e_cls == C_WR)  ref_regs[m_ins[6:0]] = e_wdata;
      if (e_cls == C_LIT) m_lit = m_ins[15:8];
    end
    if (m_busy && e_cls == C_ILL) begin m_err = 1; m_errins = m_ins; end
    else if (clr) m_err = 0;
    if (acc) begin m_busy = 1; m_ins = ins; end
    else if (e_done) m_busy = 0;
    #1;
  endtask

  task automatic cyc();
    #1; compare(); tick();
  endtask

  initial begin
    reset_n = 0; enable = 1; in_valid = 0; clear_error = 0;
    in_instruction = '0; ch_ready = '1;
    src_data = 56'({$urandom(), $urandom()});
    model_reset();
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_ch_valid", ch_valid, 0);
    check("rst_rfu_write", rfu_write, 0);
    check("rst_illegal", illegal_instruction, 0);
    check("rst_error", error, 0);
    check("rst_ch_act", ch_act, 0);
    check("rst_ch_data", ch_data, 0);
    check("rst_wr_addr", rfu_write_address, 0);
    check("rst_wr_data", rfu_write_data, 0);
    check("rst_err_ins", error_instruction, 0);
    @(posedge clock); #1;
    reset_n = 1;

    // NOP
    in_valid = 1; in_instruction = 16'h0101; cyc();
    in_valid = 0; #1; compare();
    check("nop_quiet", {rfu_write, ch_valid, illegal_instruction}, 0);
    check("nop_ready", in_ready, 1);
    tick();

    // LIT 0x2A, r5 <= literal, SEND ch1 act1 from r5 relying on forwarding
    in_valid = 1; in_instruction = 16'h2A01; cyc();
    in_instruction = 16'h0185; cyc();
    in_instruction = 16'h8506; #1; compare();
    check("wr_r5", {rfu_write, rfu_write_address, rfu_write_data}, {1'b1, 7'd5, 8'h2A});
    tick();
    in_valid = 0; #1; compare();
    check("fwd_rd_stale", rfu_read_data, 8'h00);
    check("fwd_ch1_data", ch_data[15:8], 8'h2A);
    check("fwd_ch1_act", ch_act[5:3], 3'd1);
    tick();

    // SEND ch1 act2 stalled for three cycles with a NOP waiting behind it
    ch_ready = 4'b1101; in_valid = 1; in_instruction = 16'h8507; cyc();
    in_instruction = 16'h0101;
    for (int k = 0; k < 3; k++) begin
      #1; compare();
      check("stall_valid", ch_valid, 4'b0010);
      check("stall_ready", in_ready, 0);
      tick();
    end
    ch_ready = '1; #1; compare();
    check("stall_done_ready", in_ready, 1);
    tick();
    in_valid = 0; cyc();

    // Illegal 0x0000 then clear
    in_valid = 1; in_instruction = 16'h0000; cyc();
    in_valid = 0; #1; compare();
    check("ill_pulse", illegal_instruction, 1);
    tick();
    #1; compare();
    check("ill_pulse_end", illegal_instruction, 0);
    check("err_set", error, 1);
    check("err_ins", error_instruction, 16'h0000);
    check("err_blocks", in_ready, 0);
    tick();
    clear_error = 1; cyc(); clear_error = 0;
    #1; compare();
    check("err_clr", error, 0);
    check("err_clr_ready", in_ready, 1);
    tick();

    // Bad source 9 for a register write; clear coincides with the illegal
    in_valid = 1; in_instruction = 16'h0982; cyc();
    in_valid = 0; clear_error = 1; #1; compare();
    check("ill2_pulse", illegal_instruction, 1);
    check("ill2_nowrite", rfu_write, 0);
    tick();
    clear_error = 0; #1; compare();
    check("ill2_err_wins", error, 1);
    check("ill2_err_ins", error_instruction, 16'h0982);
    tick();
    clear_error = 1; cyc(); clear_error = 0; cyc();

    // Reset in the middle of a stalled SEND
    ch_ready = '0; in_valid = 1; in_instruction = 16'h8502; cyc();
    in_valid = 0; cyc();
    #1; reset_n = 0; #1;
    check("rst_mid_send_valid", ch_valid, 0);
    check("rst_mid_send_ready", in_ready, 0);
    @(posedge clock); #1;
    reset_n = 1; ch_ready = '1; model_reset();
    cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      enable         = ($urandom_range(0, 7) != 0);
      ch_ready       = 4'($urandom());
      clear_error    = ($urandom_range(0, 3) == 0);
      src_data       = 56'({$urandom(), $urandom()});
      in_instruction = rand_instr();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
